// File: rtl/tri_bbox_scanner_pkg.sv
// Shared types and constant helpers for the triangle bounding-box scanner.
//   scan_state_t : scanner FSM state encoding
//   NVERT        : vertices per triangle
//   one_of()     : fixed-point 1.0 for a given fraction width
//   step_of()    : NDC distance between adjacent pixel centres, rounded to nearest
package tri_bbox_scanner_pkg;

    localparam int NVERT = 3;

    typedef enum logic [2:0] {
        IDLE,
        BBOX,
        CLAMP,
        START,
        SCAN
    } scan_state_t;

    function automatic int one_of(input int frac);
        return 1 << frac;
    endfunction

    // The NDC span is 2.0, so one pixel is 2^(frac+1)/res; adding res/2 rounds.
    function automatic int step_of(input int frac, input int res);
        return ((1 << (frac + 1)) + res / 2) / res;
    endfunction

endpackage

// File: rtl/tri_bbox_scanner_bbox_setup.sv
// Two-stage bounding-box setup for one triangle.
//   stage 1: per-axis signed min/max over the three vertices
//   stage 2: scale NDC extremes to pixel indices (floor), clamp to the screen,
//            and flag triangles that cover no pixel at all
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   x_tri, y_tri         packed signed NDC vertex coordinates (vertex 0 in low bits)
//   lo_x/hi_x, lo_y/hi_y clamped inclusive pixel bounding box
//   empty                bounding box holds no on-screen pixel
// The pipeline runs every cycle; outputs are valid two cycles after x_tri/y_tri
// settle and stay valid while they are held.
module tri_bbox_scanner_bbox_setup
    import tri_bbox_scanner_pkg::*;
#(
    parameter int XWIDTH = 16,
    parameter int YWIDTH = 16,
    parameter int FRAC   = 14,
    parameter int HRES   = 320,
    parameter int VRES   = 180,
    parameter int HWIDTH = $clog2(HRES),
    parameter int VWIDTH = $clog2(VRES)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NVERT*XWIDTH-1:0]  x_tri,
    input  logic [NVERT*YWIDTH-1:0]  y_tri,
    output logic [HWIDTH-1:0]        lo_x,
    output logic [HWIDTH-1:0]        hi_x,
    output logic [VWIDTH-1:0]        lo_y,
    output logic [VWIDTH-1:0]        hi_y,
    output logic                     empty
);

    localparam int ONE = one_of(FRAC);
    localparam int XPW = XWIDTH + 1 + HWIDTH;
    localparam int YPW = YWIDTH + 1 + VWIDTH;

    localparam logic signed [XWIDTH:0]   X_ONE_EXT  = (XWIDTH + 1)'(ONE);
    localparam logic signed [YWIDTH:0]   Y_ONE_EXT  = (YWIDTH + 1)'(ONE);
    localparam logic signed [XWIDTH-1:0] X_POS_ONE  = XWIDTH'(ONE);
    localparam logic signed [XWIDTH-1:0] X_NEG_ONE  = XWIDTH'(-ONE);
    localparam logic signed [YWIDTH-1:0] Y_POS_ONE  = YWIDTH'(ONE);
    localparam logic signed [YWIDTH-1:0] Y_NEG_ONE  = YWIDTH'(-ONE);
    // One extra bit keeps HRES/2 positive even when HRES is a power of two.
    localparam logic signed [HWIDTH:0]   X_HALF     = (HWIDTH + 1)'(HRES / 2);
    localparam logic signed [VWIDTH:0]   Y_HALF     = (VWIDTH + 1)'(VRES / 2);
    localparam logic signed [XPW-1:0]    X_PIX_MAX  = XPW'(HRES - 1);
    localparam logic signed [YPW-1:0]    Y_PIX_MAX  = YPW'(VRES - 1);

    logic signed [XWIDTH-1:0] xv [NVERT];
    logic signed [YWIDTH-1:0] yv [NVERT];
    logic signed [XWIDTH-1:0] xmin_c, xmax_c, xmin_q, xmax_q;
    logic signed [YWIDTH-1:0] ymin_c, ymax_c, ymin_q, ymax_q;

    logic signed [XWIDTH:0]   xmin_off, xmax_off;
    logic signed [YWIDTH:0]   ymin_off, ymax_off;
    logic signed [XPW-1:0]    xlo_s, xhi_s;
    logic signed [YPW-1:0]    ylo_s, yhi_s;
    logic [HWIDTH-1:0]        lo_x_c, hi_x_c;
    logic [VWIDTH-1:0]        lo_y_c, hi_y_c;
    logic                     empty_c;

    function automatic logic [HWIDTH-1:0] clamp_h(input logic signed [XPW-1:0] v);
        if (v[XPW-1])       return '0;
        if (v > X_PIX_MAX)  return HWIDTH'(HRES - 1);
        return v[HWIDTH-1:0];
    endfunction

    function automatic logic [VWIDTH-1:0] clamp_v(input logic signed [YPW-1:0] v);
        if (v[YPW-1])       return '0;
        if (v > Y_PIX_MAX)  return VWIDTH'(VRES - 1);
        return v[VWIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NVERT; i++) begin
            xv[i] = x_tri[i*XWIDTH +: XWIDTH];
            yv[i] = y_tri[i*YWIDTH +: YWIDTH];
        end
    end

    always_comb begin
        xmin_c = xv[0];
        xmax_c = xv[0];
        ymin_c = yv[0];
        ymax_c = yv[0];
        for (int i = 1; i < NVERT; i++) begin
            if (xv[i] < xmin_c) xmin_c = xv[i];
            if (xv[i] > xmax_c) xmax_c = xv[i];
            if (yv[i] < ymin_c) ymin_c = yv[i];
            if (yv[i] > ymax_c) ymax_c = yv[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
        end else begin
            xmin_q <= xmin_c;
            xmax_q <= xmax_c;
            ymin_q <= ymin_c;
            ymax_q <= ymax_c;
        end
    end

    // pixel = floor((ndc + 1.0) * res/2); arithmetic shift floors negatives too.
    always_comb begin
        xmin_off = (XWIDTH + 1)'(xmin_q) + X_ONE_EXT;
        xmax_off = (XWIDTH + 1)'(xmax_q) + X_ONE_EXT;
        ymin_off = (YWIDTH + 1)'(ymin_q) + Y_ONE_EXT;
        ymax_off = (YWIDTH + 1)'(ymax_q) + Y_ONE_EXT;
        xlo_s    = (XPW'(xmin_off) * XPW'(X_HALF)) >>> FRAC;
        xhi_s    = (XPW'(xmax_off) * XPW'(X_HALF)) >>> FRAC;
        ylo_s    = (YPW'(ymin_off) * YPW'(Y_HALF)) >>> FRAC;
        yhi_s    = (YPW'(ymax_off) * YPW'(Y_HALF)) >>> FRAC;
        lo_x_c   = clamp_h(xlo_s);
        hi_x_c   = clamp_h(xhi_s);
        lo_y_c   = clamp_v(ylo_s);
        hi_y_c   = clamp_v(yhi_s);
        // Clamping folds fully off-screen boxes onto an edge pixel, so the
        // raw NDC range test is needed in addition to lo>hi.
        empty_c  = (lo_x_c > hi_x_c) || (lo_y_c > hi_y_c)
                || (xmax_q < X_NEG_ONE) || (xmin_q >= X_POS_ONE)
                || (ymax_q < Y_NEG_ONE) || (ymin_q >= Y_POS_ONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lo_x  <= '0;
            hi_x  <= '0;
            lo_y  <= '0;
            hi_y  <= '0;
            empty <= 1'b0;
        end else begin
            lo_x  <= lo_x_c;
            hi_x  <= hi_x_c;
            lo_y  <= lo_y_c;
            hi_y  <= hi_y_c;
            empty <= empty_c;
        end
    end

endmodule

// File: rtl/tri_bbox_scanner.sv
// Rasterizer front end: accepts one setup triangle, derives its clamped pixel
// bounding box, then emits one pixel-centre NDC sample per cycle in row-major
// order for the barycentric interpolator.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   tri_valid_in / tri_ready_out   triangle handshake (ready only while idle)
//   x_tri_in, y_tri_in, vals_in    packed per-vertex NDC coords and attributes
//   iarea_in                       inverse doubled area, passed through
//   pix_ready_in                   downstream accepts the current sample
//   valid_out, last_out            sample valid / final sample of the triangle
//   hcount_out, vcount_out         integer pixel coordinates of the sample
//   x_out, y_out                   signed NDC pixel-centre coordinates
//   x_tri_out..iarea_out           triangle data, held for the whole triangle
//   tri_done_out                   one-cycle pulse when a triangle is finished
//
// state | meaning
// IDLE  | waiting for a triangle, ready high
// BBOX  | setup stage 1 computing vertex min/max
// CLAMP | setup stage 2 scaling and clamping the box
// START | box known: cull empty triangle or load first sample
// SCAN  | emitting samples, one per accepted handshake
module tri_bbox_scanner
    import tri_bbox_scanner_pkg::*;
#(
    parameter int XWIDTH     = 16,
    parameter int YWIDTH     = 16,
    parameter int FRAC       = 14,
    parameter int VAL_WIDTH  = 16,
    parameter int AINV_WIDTH = 16,
    parameter int HRES       = 320,
    parameter int VRES       = 180,
    parameter int HWIDTH     = $clog2(HRES),
    parameter int VWIDTH     = $clog2(VRES)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          tri_valid_in,
    output logic                          tri_ready_out,
    input  logic [NVERT*XWIDTH-1:0]       x_tri_in,
    input  logic [NVERT*YWIDTH-1:0]       y_tri_in,
    input  logic [NVERT*VAL_WIDTH-1:0]    vals_in,
    input  logic [AINV_WIDTH-1:0]         iarea_in,
    input  logic                          pix_ready_in,
    output logic                          valid_out,
    output logic                          last_out,
    output logic [HWIDTH-1:0]             hcount_out,
    output logic [VWIDTH-1:0]             vcount_out,
    output logic signed [XWIDTH-1:0]      x_out,
    output logic signed [YWIDTH-1:0]      y_out,
    output logic [NVERT*XWIDTH-1:0]       x_tri_out,
    output logic [NVERT*YWIDTH-1:0]       y_tri_out,
    output logic [NVERT*VAL_WIDTH-1:0]    vals_out,
    output logic [AINV_WIDTH-1:0]         iarea_out,
    output logic                          tri_done_out
);

    localparam int ONE   = one_of(FRAC);
    localparam int XSTEP = step_of(FRAC, HRES);
    localparam int YSTEP = step_of(FRAC, VRES);
    localparam logic signed [XWIDTH-1:0] X_STEP_W = XWIDTH'(XSTEP);
    localparam logic signed [YWIDTH-1:0] Y_STEP_W = YWIDTH'(YSTEP);

    scan_state_t state_q, state_d;

    logic [NVERT*XWIDTH-1:0]    x_tri_q;
    logic [NVERT*YWIDTH-1:0]    y_tri_q;
    logic [NVERT*VAL_WIDTH-1:0] vals_q;
    logic [AINV_WIDTH-1:0]      iarea_q;

    logic [HWIDTH-1:0]          lo_x, hi_x, h_q;
    logic [VWIDTH-1:0]          lo_y, hi_y, v_q;
    logic                       bbox_empty;

    logic                       valid_q, done_q;
    logic signed [XWIDTH-1:0]   x_q, x_start_q, x_start_c;
    logic signed [YWIDTH-1:0]   y_q, y_start_c;
    logic                       accept, fire, last_c;

    tri_bbox_scanner_bbox_setup #(
        .XWIDTH (XWIDTH),
        .YWIDTH (YWIDTH),
        .FRAC   (FRAC),
        .HRES   (HRES),
        .VRES   (VRES),
        .HWIDTH (HWIDTH),
        .VWIDTH (VWIDTH)
    ) u_bbox (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .x_tri  (x_tri_q),
        .y_tri  (y_tri_q),
        .lo_x   (lo_x),
        .hi_x   (hi_x),
        .lo_y   (lo_y),
        .hi_y   (hi_y),
        .empty  (bbox_empty)
    );

    assign tri_ready_out = (state_q == IDLE) & ~rst_in;
    assign accept        = tri_valid_in & tri_ready_out;
    assign fire          = valid_q & pix_ready_in;
    assign last_c        = (h_q == hi_x) && (v_q == hi_y);

    // Row starts are computed from lo directly, so each row reloads an exact
    // value instead of inheriting rounding drift from the previous row.
    always_comb begin
        x_start_c = XWIDTH'(XSTEP / 2 - ONE + int'(lo_x) * XSTEP);
        y_start_c = YWIDTH'(YSTEP / 2 - ONE + int'(lo_y) * YSTEP);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BBOX;
            BBOX:    state_d = CLAMP;
            CLAMP:   state_d = START;
            START:   state_d = bbox_empty ? IDLE : SCAN;
            SCAN:    if (fire && last_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_tri_q   <= '0;
            y_tri_q   <= '0;
            vals_q    <= '0;
            iarea_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                x_tri_q <= x_tri_in;
                y_tri_q <= y_tri_in;
                vals_q  <= vals_in;
                iarea_q <= iarea_in;
            end
            if (state_q == START) begin
                if (bbox_empty) begin
                    done_q <= 1'b1;
                end else begin
                    valid_q   <= 1'b1;
                    h_q       <= lo_x;
                    v_q       <= lo_y;
                    x_q       <= x_start_c;
                    x_start_q <= x_start_c;
                    y_q       <= y_start_c;
                end
            end
            if (state_q == SCAN && fire) begin
                if (last_c) begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                end else if (h_q == hi_x) begin
                    h_q <= lo_x;
                    v_q <= v_q + VWIDTH'(1);
                    x_q <= x_start_q;
                    y_q <= y_q + Y_STEP_W;
                end else begin
                    h_q <= h_q + HWIDTH'(1);
                    x_q <= x_q + X_STEP_W;
                end
            end
        end
    end

    assign valid_out    = valid_q;
    assign last_out     = valid_q & last_c;
    assign hcount_out   = h_q;
    assign vcount_out   = v_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign x_tri_out    = x_tri_q;
    assign y_tri_out    = y_tri_q;
    assign vals_out     = vals_q;
    assign iarea_out    = iarea_q;
    assign tri_done_out = done_q;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
module tb_tri_bbox_scanner;

    localparam int FRAC = 14;
    localparam int ONE  = 1 << FRAC;
    localparam int HRES = 320;
    localparam int VRES = 180;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        tri_valid_in;
    logic        tri_ready_out;
    logic [47:0] x_tri_in, y_tri_in, vals_in;
    logic [15:0] iarea_in;
    logic        pix_ready_in;
    logic        valid_out, last_out, tri_done_out;
    logic [8:0]  hcount_out;
    logic [7:0]  vcount_out;
    logic signed [15:0] x_out, y_out;
    logic [47:0] x_tri_out, y_tri_out, vals_out;
    logic [15:0] iarea_out;

    tri_bbox_scanner dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .tri_valid_in  (tri_valid_in),
        .tri_ready_out (tri_ready_out),
        .x_tri_in      (x_tri_in),
        .y_tri_in      (y_tri_in),
        .vals_in       (vals_in),
        .iarea_in      (iarea_in),
        .pix_ready_in  (pix_ready_in),
        .valid_out     (valid_out),
        .last_out      (last_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .x_out         (x_out),
        .y_out         (y_out),
        .x_tri_out     (x_tri_out),
        .y_tri_out     (y_tri_out),
        .vals_out      (vals_out),
        .iarea_out     (iarea_out),
        .tri_done_out  (tri_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          h;
        int          v;
        int          x;
        int          y;
        bit          last;
        logic [47:0] xt;
        logic [47:0] vt;
        logic [15:0] ia;
    } exp_t;

    exp_t q[$];
    int   exp_npix[$];

    int total = 0;
    int bad   = 0;
    int xstep, ystep;
    bit stall_en = 0;

    int done_cnt = 0, exp_done = 0, hs_cnt = 0, pix_in_tri = 0;
    int first_h, first_v, first_x, first_y, last_h, last_v, last_pix;
    longint sig = 0, last_sig = 0;
    bit held_v = 0;
    int held_h, held_vv, held_x, held_y;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pk(input int a, input int b, input int c);
        logic [15:0] a16, b16, c16;
        a16 = a[15:0];
        b16 = b[15:0];
        c16 = c[15:0];
        return {c16, b16, a16};
    endfunction

    function automatic int fdiv(input longint a, input longint b);
        longint r;
        r = a / b;
        if ((a % b != 0) && (a < 0)) r = r - 1;
        return int'(r);
    endfunction

    // Pixel range covered by one axis, straight from the bbox rules.
    task automatic axis(input int c0, input int c1, input int c2, input int res,
                        output int lo, output int hi, output bit emp);
        int mn, mx;
        mn = c0; if (c1 < mn) mn = c1; if (c2 < mn) mn = c2;
        mx = c0; if (c1 > mx) mx = c1; if (c2 > mx) mx = c2;
        lo = fdiv(longint'(mn + ONE) * (res / 2), ONE);
        hi = fdiv(longint'(mx + ONE) * (res / 2), ONE);
        if (lo < 0) lo = 0; if (lo > res - 1) lo = res - 1;
        if (hi < 0) hi = 0; if (hi > res - 1) hi = res - 1;
        emp = (lo > hi) || (mx < -ONE) || (mn >= ONE);
    endtask

    task automatic model_push(input logic [47:0] xt, input logic [47:0] yt,
                              input logic [47:0] vt, input logic [15:0] ia);
        int xs[3], ys[3];
        int lx, hx, ly, hy, n;
        bit ex, ey;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            xs[i] = int'($signed(xt[i*16 +: 16]));
            ys[i] = int'($signed(yt[i*16 +: 16]));
        end
        axis(xs[0], xs[1], xs[2], HRES, lx, hx, ex);
        axis(ys[0], ys[1], ys[2], VRES, ly, hy, ey);
        n = 0;
        if (!(ex || ey)) begin
            for (int v = ly; v <= hy; v++) begin
                for (int h = lx; h <= hx; h++) begin
                    e.h    = h;
                    e.v    = v;
                    e.x    = -ONE + xstep / 2 + h * xstep;
                    e.y    = -ONE + ystep / 2 + v * ystep;
                    e.last = (h == hx) && (v == hy);
                    e.xt   = xt;
                    e.vt   = vt;
                    e.ia   = ia;
                    q.push_back(e);
                    n++;
                end
            end
        end
        exp_npix.push_back(n);
    endtask

    // Returns at the posedge+1 following the accept edge.
    task automatic send_tri(input logic [47:0] xt, input logic [47:0] yt,
                            input logic [47:0] vt, input logic [15:0] ia);
        int n;
        n = 0;
        while (!tri_ready_out && n < 100000) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (!tri_ready_out) begin
            $display("FAIL ready_timeout: tri_ready_out never rose");
            $fatal(1);
        end
        tri_valid_in = 1'b1;
        x_tri_in     = xt;
        y_tri_in     = yt;
        vals_in      = vt;
        iarea_in     = ia;
        @(posedge clk_in); #1;
        tri_valid_in = 1'b0;
        x_tri_in     = {16'($urandom), 32'($urandom)};
        y_tri_in     = {16'($urandom), 32'($urandom)};
        vals_in      = {16'($urandom), 32'($urandom)};
        iarea_in     = 16'($urandom);
        model_push(xt, yt, vt, ia);
        exp_done++;
    endtask

    task automatic measure_latency(output int n);
        n = 0;
        while (!valid_out && !tri_done_out && n < 20) begin
            @(posedge clk_in); #1;
            n++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt != exp_done && n < budget) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("tri_done_count", done_cnt, exp_done);
    endtask

    initial begin
        forever begin
            @(posedge clk_in); #1;
            pix_ready_in = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk_in) begin
        exp_t e;
        int npx;
        if (rst_in) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                check("stall_valid_hold", valid_out, 1);
                check("stall_h_hold", hcount_out, held_h);
                check("stall_v_hold", vcount_out, held_vv);
                check("stall_x_hold", $signed(x_out), held_x);
                check("stall_y_hold", $signed(y_out), held_y);
            end
            held_v = 0;
            if (valid_out && pix_ready_in) begin
                if (q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("hcount", hcount_out, e.h);
                    check("vcount", vcount_out, e.v);
                    check("x_out", $signed(x_out), e.x);
                    check("y_out", $signed(y_out), e.y);
                    check("last_out", last_out, e.last);
                    check("x_tri_out", x_tri_out, e.xt);
                    check("vals_out", vals_out, e.vt);
                    check("iarea_out", iarea_out, e.ia);
                end
                if (pix_in_tri == 0) begin
                    first_h = hcount_out;
                    first_v = vcount_out;
                    first_x = $signed(x_out);
                    first_y = $signed(y_out);
                end
                last_h = hcount_out;
                last_v = vcount_out;
                sig    = sig * 31 + longint'($signed(x_out)) * 7 + longint'($signed(y_out));
                pix_in_tri++;
                hs_cnt++;
            end else if (valid_out) begin
                held_v  = 1;
                held_h  = hcount_out;
                held_vv = vcount_out;
                held_x  = $signed(x_out);
                held_y  = $signed(y_out);
            end
            if (tri_done_out) begin
                done_cnt++;
                check("queue_empty_at_done", q.size(), 0);
                if (exp_npix.size() == 0) begin
                    check("unexpected_tri_done", 1, 0);
                end else begin
                    npx = exp_npix.pop_front();
                    check("tri_pixel_count", pix_in_tri, npx);
                end
                last_pix   = pix_in_tri;
                last_sig   = sig;
                pix_in_tri = 0;
                sig        = 0;
            end
        end
    end

    initial begin
        repeat (120000) @(posedge clk_in);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int n, d0, h0, tmp;
        longint sig_ref;
        logic [47:0] xa, ya, xb, yb;

        xstep = $rtoi(real'(1 << (FRAC + 1)) / HRES + 0.5);
        ystep = $rtoi(real'(1 << (FRAC + 1)) / VRES + 0.5);

        rst_in = 1'b1; tri_valid_in = 1'b0; pix_ready_in = 1'b1;
        x_tri_in = '0; y_tri_in = '0; vals_in = '0; iarea_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_done", tri_done_out, 0);
        check("rst_ready", tri_ready_out, 0);
        check("rst_hcount", hcount_out, 0);
        check("rst_vcount", vcount_out, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_xtri", x_tri_out, 0);
        check("rst_vals", vals_out, 0);
        check("rst_iarea", iarea_out, 0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check("ready_after_reset", tri_ready_out, 1);

        // full screen
        send_tri(pk(-ONE, ONE, -ONE), pk(-ONE, -ONE, ONE), pk(100, 200, 300), 16'h1234);
        measure_latency(n);
        check("fs_first_valid_latency", n, 3);
        wait_done(70000);
        check("fs_pixels", last_pix, 57600);
        check("fs_first_x", first_x, -16333);
        check("fs_first_y", first_y, -16293);
        check("fs_last_h", last_h, 319);
        check("fs_last_v", last_v, 179);

        // small triangle, unstalled reference
        d0 = done_cnt;
        send_tri(pk(0, 819, 0), pk(0, 0, 819), pk(7, 8, 9), 16'h0042);
        measure_latency(n);
        check("small_first_valid_latency", n, 3);
        check("small_no_early_done", tri_done_out, 0);
        wait_done(500);
        repeat (5) @(posedge clk_in);
        #1;
        check("small_done_once", done_cnt - d0, 1);
        check("small_pixels", last_pix, 40);
        check("small_first_h", first_h, 160);
        check("small_first_v", first_v, 90);
        check("small_last_h", last_h, 167);
        check("small_last_v", last_v, 94);
        sig_ref = last_sig;

        // off-screen cull
        h0 = hs_cnt;
        send_tri(pk(20000, 25000, 30000), pk(0, 100, 200), pk(1, 2, 3), 16'h0001);
        measure_latency(n);
        check("cull_done_latency", n, 3);
        check("cull_done_pulse", tri_done_out, 1);
        check("cull_no_valid", valid_out, 0);
        @(posedge clk_in); #1;
        check("cull_ready_returns", tri_ready_out, 1);
        check("cull_no_pixels", hs_cnt - h0, 0);
        wait_done(50);

        // same small triangle under random stalls
        stall_en = 1;
        send_tri(pk(0, 819, 0), pk(0, 0, 819), pk(7, 8, 9), 16'h0042);
        wait_done(2000);
        check("stall_pixels", last_pix, 40);
        check("stall_sequence_matches", last_sig, sig_ref);
        stall_en = 0;

        // reset at pixel 10 of a full-screen triangle
        send_tri(pk(-ONE, ONE, -ONE), pk(-ONE, -ONE, ONE), pk(4, 5, 6), 16'h0777);
        h0 = hs_cnt;
        n = 0;
        while (hs_cnt - h0 < 10 && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("reset_reached_pixel10", hs_cnt - h0, 10);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("reset_valid_drops", valid_out, 0);
        check("reset_no_done", tri_done_out, 0);
        rst_in = 1'b0;
        q.delete();
        tmp = exp_npix.pop_back();
        exp_done--;
        pix_in_tri = 0;
        sig = 0;
        d0 = done_cnt;
        repeat (4) @(posedge clk_in);
        #1;
        check("reset_no_late_done", done_cnt, d0);
        send_tri(pk(0, 819, 0), pk(0, 0, 819), pk(10, 11, 12), 16'h0099);
        wait_done(500);
        check("post_reset_pixels", last_pix, 40);

        // back-to-back
        xa = pk(-3000, -1500, -2500); ya = pk(1000, 1200, 2500);
        xb = pk(5000, 6100, 5200);    yb = pk(-4000, -3900, -2600);
        send_tri(xa, ya, pk(21, 22, 23), 16'h0a0a);
        send_tri(xb, yb, pk(31, 32, 33), 16'h0b0b);
        wait_done(2000);

        // random triangles, random stalling, issued back-to-back
        for (int t = 0; t < 8; t++) begin
            int cx, cy;
            stall_en = 1'($urandom_range(0, 1));
            cx = int'($urandom_range(0, 36000)) - 18000;
            cy = int'($urandom_range(0, 36000)) - 18000;
            send_tri(pk(cx + int'($urandom_range(0, 1200)), cx + int'($urandom_range(0, 1200)),
                        cx + int'($urandom_range(0, 1200))),
                     pk(cy + int'($urandom_range(0, 1200)), cy + int'($urandom_range(0, 1200)),
                        cy + int'($urandom_range(0, 1200))),
                     {16'($urandom), 32'($urandom)}, 16'($urandom));
        end
        wait_done(20000);
        stall_en = 0;
        repeat (4) @(posedge clk_in);
        #1;
        check("no_leftover_samples", q.size(), 0);
        check("no_leftover_tris", exp_npix.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
